// File: rtl/ticket_vend_ctrl_if.sv
// Bundle of the ticket_vend_ctrl front-panel, coin-acceptor, printer and
// coin-return signals. The "master" side is the surrounding machine logic and
// the "slave" side is the controller itself.
interface ticket_vend_ctrl_if #(
  parameter int NUM_DEST = 8,
  parameter int MONEY_W  = 10,
  parameter int CNT_W    = 3
);
  localparam int DEST_W = $clog2(NUM_DEST);

  logic               start;
  logic [DEST_W-1:0]  dest_sel;
  logic [CNT_W-1:0]   ticket_count;
  logic               coin_valid;
  logic [MONEY_W-1:0] coin_value;
  logic               cancel;
  logic               ticket_ready;
  logic               payout_ready;
  logic               busy;
  logic [MONEY_W-1:0] credit;
  logic               ticket_valid;
  logic [DEST_W-1:0]  ticket_dest;
  logic               payout_valid;
  logic [MONEY_W-1:0] payout_amt;
  logic               payout_is_refund;
  logic               err;

  modport master (
    output start, dest_sel, ticket_count, coin_valid, coin_value, cancel,
           ticket_ready, payout_ready,
    input  busy, credit, ticket_valid, ticket_dest, payout_valid, payout_amt,
           payout_is_refund, err
  );

  modport slave (
    input  start, dest_sel, ticket_count, coin_valid, coin_value, cancel,
           ticket_ready, payout_ready,
    output busy, credit, ticket_valid, ticket_dest, payout_valid, payout_amt,
           payout_is_refund, err
  );
endinterface

// File: rtl/ticket_vend_ctrl.sv
// ticket_vend_ctrl: metro ticket-vending controller.
// Latches a destination and quantity, collects coins until the fare is covered,
// hands tickets to the printer one per handshake and returns change; cancel
// refunds whatever credit has been collected.
// Optional build macro TICKET_TIMEOUT_EN adds an inactivity timeout in COLLECT
// that behaves like cancel after TIMEOUT_CYCLES coin-free cycles.
module ticket_vend_ctrl #(
  parameter int NUM_DEST       = 8,
  parameter int FARE_BASE      = 10,
  parameter int FARE_STEP      = 20,
  parameter int MONEY_W        = 10,
  parameter int CNT_W          = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic            clk,
  input logic            arstn,
  ticket_vend_ctrl_if.slave bus
);

  localparam int DEST_W = $clog2(NUM_DEST);
  localparam int TOT_W  = MONEY_W + CNT_W;
  localparam logic [MONEY_W-1:0] MONEY_MAX = {MONEY_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_COLLECT  = 3'd2,
    S_DISPENSE = 3'd3,
    S_PAYOUT   = 3'd4,
    S_REJECT   = 3'd5
  } state_t;

  state_t             state_r;
  logic [DEST_W-1:0]  dest_r;
  logic [CNT_W-1:0]   qty_r;
  logic [CNT_W-1:0]   remaining_r;
  logic [MONEY_W-1:0] total_r;
  logic [MONEY_W-1:0] credit_r;
  logic [MONEY_W-1:0] payout_amt_r;
  logic               busy_r;
  logic               ticket_valid_r;
  logic [DEST_W-1:0]  ticket_dest_r;
  logic               payout_valid_r;
  logic               payout_is_refund_r;
  logic               err_r;

  logic [TOT_W-1:0]   fare_s;
  logic [TOT_W-1:0]   total_s;
  logic               req_bad_s;
  logic [MONEY_W-1:0] credit_in_s;
  logic               timeout_s;
  logic               abort_s;

  // Money addition that sticks at the all-ones value instead of wrapping.
  function automatic logic [MONEY_W-1:0] sat_add(input logic [MONEY_W-1:0] a,
                                                 input logic [MONEY_W-1:0] b);
    logic [MONEY_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[MONEY_W] ? MONEY_MAX : sum[MONEY_W-1:0];
  endfunction

  // Fare, order total, request validity and the credit including this cycle's coin.
  always_comb begin
    fare_s      = TOT_W'(FARE_BASE) + (TOT_W'(dest_r) - TOT_W'(1'b1)) * TOT_W'(FARE_STEP);
    total_s     = fare_s * TOT_W'(qty_r);
    req_bad_s   = (dest_r == {DEST_W{1'b0}})
               || (32'(dest_r) >= 32'(NUM_DEST))
               || (qty_r == {CNT_W{1'b0}})
               || (fare_s > TOT_W'(MONEY_MAX))
               || (total_s > TOT_W'(MONEY_MAX));
    credit_in_s = bus.coin_valid ? sat_add(credit_r, bus.coin_value) : credit_r;
    abort_s     = bus.cancel || timeout_s;
  end

`ifdef TICKET_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_r;

  // Inactivity counter: runs only in COLLECT and restarts on every coin.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if ((state_r != S_COLLECT) || bus.coin_valid) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end
  end

  // The edge that would bring the count to TIMEOUT_CYCLES acts as a cancel.
  assign timeout_s = (state_r == S_COLLECT) && !bus.coin_valid
                  && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
  assign timeout_s        = 1'b0;
`endif

  // Transaction state machine; every output is a register updated with the state.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r            <= S_IDLE;
      dest_r             <= {DEST_W{1'b0}};
      qty_r              <= {CNT_W{1'b0}};
      remaining_r        <= {CNT_W{1'b0}};
      total_r            <= {MONEY_W{1'b0}};
      credit_r           <= {MONEY_W{1'b0}};
      payout_amt_r       <= {MONEY_W{1'b0}};
      busy_r             <= 1'b0;
      ticket_valid_r     <= 1'b0;
      ticket_dest_r      <= {DEST_W{1'b0}};
      payout_valid_r     <= 1'b0;
      payout_is_refund_r <= 1'b0;
      err_r              <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            dest_r   <= bus.dest_sel;
            qty_r    <= bus.ticket_count;
            credit_r <= {MONEY_W{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= S_CHECK;
          end
        end
        S_CHECK: begin
          total_r <= total_s[MONEY_W-1:0];
          if (req_bad_s) begin
            err_r   <= 1'b1;
            state_r <= S_REJECT;
          end else begin
            state_r <= S_COLLECT;
          end
        end
        S_REJECT: begin
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        S_COLLECT: begin
          credit_r <= credit_in_s;
          if (abort_s) begin
            if (credit_in_s != {MONEY_W{1'b0}}) begin
              payout_amt_r       <= credit_in_s;
              payout_is_refund_r <= 1'b1;
              payout_valid_r     <= 1'b1;
              state_r            <= S_PAYOUT;
            end else begin
              busy_r  <= 1'b0;
              state_r <= S_IDLE;
            end
          end else if (credit_r >= total_r) begin
            remaining_r    <= qty_r;
            ticket_valid_r <= 1'b1;
            ticket_dest_r  <= dest_r;
            state_r        <= S_DISPENSE;
          end
        end
        S_DISPENSE: begin
          if (bus.ticket_ready) begin
            remaining_r <= remaining_r - 1'b1;
            if (remaining_r == CNT_W'(1'b1)) begin
              ticket_valid_r <= 1'b0;
              if (credit_r != total_r) begin
                payout_amt_r       <= credit_r - total_r;
                payout_is_refund_r <= 1'b0;
                payout_valid_r     <= 1'b1;
                state_r            <= S_PAYOUT;
              end else begin
                busy_r  <= 1'b0;
                state_r <= S_IDLE;
              end
            end
          end
        end
        S_PAYOUT: begin
          if (bus.payout_ready) begin
            payout_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            state_r        <= S_IDLE;
          end
        end
        default: begin
          busy_r         <= 1'b0;
          ticket_valid_r <= 1'b0;
          payout_valid_r <= 1'b0;
          err_r          <= 1'b0;
          state_r        <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy             = busy_r;
  assign bus.credit           = credit_r;
  assign bus.ticket_valid     = ticket_valid_r;
  assign bus.ticket_dest      = ticket_dest_r;
  assign bus.payout_valid     = payout_valid_r;
  assign bus.payout_amt       = payout_amt_r;
  assign bus.payout_is_refund = payout_is_refund_r;
  assign bus.err              = err_r;

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Self-checking bench for ticket_vend_ctrl: a table of transactions with their
// expected tickets, payouts and error pulses feeds a scoreboard queue that a
// handshake monitor drains; hand-written sequences cover payout stall, reset
// mid-dispense and the inactivity timeout (TICKET_TIMEOUT_EN).
module tb_ticket_vend_ctrl;

  logic clk   = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  ticket_vend_ctrl_if #(.NUM_DEST(8), .MONEY_W(10), .CNT_W(3)) bus ();

  ticket_vend_ctrl #(
    .NUM_DEST(8), .FARE_BASE(10), .FARE_STEP(20), .MONEY_W(10), .CNT_W(3),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .arstn(arstn),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int kind;    // 0 ticket, 1 payout, 2 err pulse
    int val;
    int refund;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [2:0]       dest;
    logic [2:0]       qty;
    int               ncoin;
    logic [3:0][9:0]  coin;
    bit               cancel_last;
    bit               exp_err;
    int               exp_tickets;
    bit               exp_pay;
    int               exp_amt;
    bit               exp_refund;
    int               exp_credit;
  } vec_t;
  vec_t vecs[10];

  int tr_mode = 1;  // 0 low, 1 high, 2 random
  int pr_mode = 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int dest, int qty, int ncoin, int c0, int c1, int c2, int c3,
                              bit cl, bit e_err, int e_tk, bit e_pay, int e_amt,
                              bit e_rf, int e_cr);
    vec_t v;
    v.dest = 3'(dest); v.qty = 3'(qty); v.ncoin = ncoin;
    v.coin[0] = 10'(c0); v.coin[1] = 10'(c1); v.coin[2] = 10'(c2); v.coin[3] = 10'(c3);
    v.cancel_last = cl; v.exp_err = e_err; v.exp_tickets = e_tk; v.exp_pay = e_pay;
    v.exp_amt = e_amt; v.exp_refund = e_rf; v.exp_credit = e_cr;
    return v;
  endfunction

  task automatic observe(input int kind, input int val, input int rf);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: actual kind %0d val %0d required none", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_value", val, e.val);
      check("event_refund", rf, e.refund);
    end
  endtask

  // Handshake monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (arstn) begin
      if (bus.ticket_valid && bus.ticket_ready) observe(0, int'(bus.ticket_dest), 0);
      if (bus.payout_valid && bus.payout_ready) observe(1, int'(bus.payout_amt), int'(bus.payout_is_refund));
      if (bus.err) observe(2, 0, 0);
    end
  end

  // Printer / coin-return ready generators.
  always @(posedge clk) begin
    #1;
    bus.ticket_ready = (tr_mode == 2) ? 1'($urandom_range(0, 1)) : (tr_mode == 1);
    bus.payout_ready = (pr_mode == 2) ? 1'($urandom_range(0, 1)) : (pr_mode == 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  task automatic launch(input vec_t v);
    ev_t e;
    if (v.exp_err) begin e.kind = 2; e.val = 0; e.refund = 0; exp_q.push_back(e); end
    for (int t = 0; t < v.exp_tickets; t++) begin
      e.kind = 0; e.val = int'(v.dest); e.refund = 0; exp_q.push_back(e);
    end
    if (v.exp_pay) begin e.kind = 1; e.val = v.exp_amt; e.refund = int'(v.exp_refund); exp_q.push_back(e); end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dest_sel = v.dest; bus.ticket_count = v.qty;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < v.ncoin; c++) begin
      bus.coin_valid = 1'b1;
      bus.coin_value = v.coin[c];
      bus.cancel     = v.cancel_last && (c == v.ncoin - 1);
      @(posedge clk); #1;
      bus.coin_valid = 1'b0;
      bus.cancel     = 1'b0;
    end
    if (v.ncoin == 0 && v.cancel_last) begin
      bus.cancel = 1'b1;
      @(posedge clk); #1;
      bus.cancel = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, int'(bus.busy), 0);
    @(posedge clk); #1;
    check({tag, "_events_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int k;
    int saw;
    bus.start = 1'b0; bus.dest_sel = 3'd0; bus.ticket_count = 3'd0;
    bus.coin_valid = 1'b0; bus.coin_value = 10'd0; bus.cancel = 1'b0;
    bus.ticket_ready = 1'b1; bus.payout_ready = 1'b1;

    //         dest qty n  c0   c1   c2  c3 cl  err tk pay amt rf credit
    vecs[0] = mk(3, 2, 2,  50,  50,  0, 0, 0,  0, 2, 0,  0,  0, 100);
    vecs[1] = mk(2, 1, 2,  20,  20,  0, 0, 0,  0, 1, 1, 10,  0,  40);
    vecs[2] = mk(5, 1, 2,  20,  10,  0, 0, 1,  0, 0, 1, 30,  1,  30);
    vecs[3] = mk(0, 1, 0,   0,   0,  0, 0, 0,  1, 0, 0,  0,  0,   0);
    vecs[4] = mk(1, 0, 0,   0,   0,  0, 0, 0,  1, 0, 0,  0,  0,   0);
    vecs[5] = mk(7, 7, 2, 500, 500,  0, 0, 0,  0, 7, 1, 90,  0, 1000);
    vecs[6] = mk(7, 7, 2, 800, 300,  0, 0, 0,  0, 7, 1, 113, 0, 1023);
    vecs[7] = mk(4, 1, 0,   0,   0,  0, 0, 1,  0, 0, 0,  0,  0,   0);
    vecs[8] = mk(1, 3, 3,  10,  10, 10, 0, 0,  0, 3, 0,  0,  0,  30);
    vecs[9] = mk(6, 1, 1, 200,   0,  0, 0, 0,  0, 1, 1, 90,  0, 200);

    // Reset values
    #2;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_credit", int'(bus.credit), 0);
    check("rst_ticket_valid", int'(bus.ticket_valid), 0);
    check("rst_ticket_dest", int'(bus.ticket_dest), 0);
    check("rst_payout_valid", int'(bus.payout_valid), 0);
    check("rst_payout_amt", int'(bus.payout_amt), 0);
    check("rst_refund", int'(bus.payout_is_refund), 0);
    check("rst_err", int'(bus.err), 0);
    #10 arstn = 1'b1;

    // Table-driven transactions with random backpressure
    tr_mode = 2; pr_mode = 2;
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i]);
      wait_idle($sformatf("v%0d", i));
      check($sformatf("v%0d_credit", i), int'(bus.credit), vecs[i].exp_credit);
    end

    // Change payout held while payout_ready is low
    tr_mode = 1; pr_mode = 0;
    launch(vecs[1]);
    n = 0;
    while (!bus.payout_valid && n < 100) begin @(negedge clk); n++; end
    check("hold_reach", int'(bus.payout_valid), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", int'(bus.payout_valid), 1);
      check("hold_amt", int'(bus.payout_amt), 10);
      check("hold_refund", int'(bus.payout_is_refund), 0);
    end
    pr_mode = 1;
    wait_idle("hold");

    // Reset asserted mid-DISPENSE with the printer stalled
    tr_mode = 0;
    launch(vecs[0]);
    n = 0;
    while (!bus.ticket_valid && n < 100) begin @(negedge clk); n++; end
    check("mid_reach_dispense", int'(bus.ticket_valid), 1);
    @(negedge clk);
    check("mid_stall_valid", int'(bus.ticket_valid), 1);
    check("mid_stall_dest", int'(bus.ticket_dest), 3);
    #1 arstn = 1'b0;
    #1;
    check("mid_rst_ticket_valid", int'(bus.ticket_valid), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_credit", int'(bus.credit), 0);
    check("mid_rst_payout_valid", int'(bus.payout_valid), 0);
    exp_q.delete();
    #1 arstn = 1'b1;
    tr_mode = 1;
    @(negedge clk);
    check("mid_rst_stays_idle", int'(bus.busy), 0);

    // Inactivity: one coin of 20 then nothing
    pr_mode = 1;
    launch(mk(5, 1, 1, 20, 0, 0, 0, 0, 0, 0, 1, 20, 1, 20));
`ifdef TICKET_TIMEOUT_EN
    k = 0;
    while (!bus.payout_valid && k < 200) begin @(posedge clk); #1; k++; end
    check("timeout_cycles", k, 100);
    check("timeout_amt", int'(bus.payout_amt), 20);
    check("timeout_refund", int'(bus.payout_is_refund), 1);
    wait_idle("timeout");
`else
    saw = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bus.payout_valid) saw = 1;
    end
    check("no_timeout_payout", saw, 0);
    check("no_timeout_busy", int'(bus.busy), 1);
    @(posedge clk); #1;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    wait_idle("late_cancel");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
